// File: rtl/frame_pkg.sv
// Shared frame geometry, header index layout and FSM state encoding for the
// frame write path.
package frame_pkg;

  localparam int unsigned ROWS_PER_FRAME = 100;
  localparam int unsigned ROW_BITS       = 2640;
  localparam int unsigned HDR_BITS       = 240;

  // Row index lives in the first IDX_BITS of the header, bit 0 is the MSB.
  localparam int unsigned IDX_BITS = 16;
  localparam int unsigned CNT_BITS = 7;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CAPTURE = 3'd1;
  localparam logic [2:0] DRAIN   = 3'd2;
  localparam logic [2:0] FLUSH   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

endpackage

// File: rtl/row_hdr_check.sv
// Extracts the row index from a row header and compares it with the index the
// controller expects next; purely combinational.
module row_hdr_check #(
  parameter int unsigned ROWS_PER_FRAME = frame_pkg::ROWS_PER_FRAME
) (
  input  logic [0:frame_pkg::IDX_BITS-1] idx_field,
  input  logic [frame_pkg::CNT_BITS-1:0] expected_idx,
  output logic                           idx_ok,
  output logic                           idx_last
);
  import frame_pkg::*;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ROWS_PER_FRAME - 1);

  // Ascending-range field maps bit 0 onto the MSB of the descending vector.
  logic [IDX_BITS-1:0] row_idx;
  assign row_idx = idx_field;

  assign idx_ok   = (row_idx == IDX_BITS'(expected_idx));
  assign idx_last = (row_idx == LAST_IDX);

endmodule

// File: rtl/frame_write_ctrl.sv
// Captures one frame of indexed rows, forwards in-order rows to the image
// writer, then handshakes a file flush and pulses frame_done.
module frame_write_ctrl #(
  parameter int unsigned ROWS_PER_FRAME = frame_pkg::ROWS_PER_FRAME,
  parameter int unsigned ROW_BITS       = frame_pkg::ROW_BITS,
  parameter int unsigned HDR_BITS       = frame_pkg::HDR_BITS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           row_valid,
  input  logic [0:ROW_BITS-1]            row_data,
  output logic                           row_ready,
  output logic                           write,
  output logic [0:ROW_BITS-1]            FrameDataOut,
  output logic                           flush_req,
  input  logic                           flush_ack,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           row_err,
  output logic [frame_pkg::CNT_BITS-1:0] rows_written
);
  import frame_pkg::*;

  // Header must hold the index and leave room for payload; counter must reach
  // ROWS_PER_FRAME.
  if ((HDR_BITS < IDX_BITS) || (HDR_BITS >= ROW_BITS) ||
      (ROWS_PER_FRAME >= (1 << CNT_BITS)) || (ROWS_PER_FRAME == 0)) begin : g_bad_params
    $error("frame_write_ctrl: inconsistent frame geometry parameters");
  end

  logic [2:0] state;
  logic       accept;
  logic       idx_ok;
  logic       idx_last;

  row_hdr_check #(
    .ROWS_PER_FRAME (ROWS_PER_FRAME)
  ) u_hdr_check (
    .idx_field    (row_data[0:IDX_BITS-1]),
    .expected_idx (rows_written),
    .idx_ok       (idx_ok),
    .idx_last     (idx_last)
  );

  assign row_ready  = (state == CAPTURE);
  assign accept     = row_valid & row_ready;
  assign busy       = (state != IDLE);
  assign flush_req  = (state == FLUSH);
  assign frame_done = (state == DONE);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      write        <= 1'b0;
      // NOTE: a wide datapath register would normally skip reset; this one is
      // reset because the writer must see all-zero data out of reset.
      FrameDataOut <= '0;
      row_err      <= 1'b0;
      rows_written <= '0;
    end else begin
      write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= CAPTURE;
            rows_written <= '0;
            row_err      <= 1'b0;
          end
        end
        CAPTURE: begin
          if (accept) begin
            if (idx_ok) begin
              write        <= 1'b1;
              FrameDataOut <= row_data;
              rows_written <= rows_written + 1'b1;
              if (idx_last) state <= DRAIN;
            end else begin
              // Out-of-order row is dropped; keep waiting for the same index.
              row_err <= 1'b1;
            end
          end
        end
        DRAIN:   state <= FLUSH;
        FLUSH:   if (flush_ack) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
